// File: rtl/xbus_ram.sv
`default_nettype none
// ============================================================================
//  Module   : xbus_ram
//  Purpose  : Word-addressed xbus target memory for the disk DMA engine.
//             Decodes a fixed window, inserts WAIT wait states, completes
//             each transfer with a one-cycle ack and counts completed
//             reads and writes.
//  Revision : 1.0 - initial release
// ============================================================================
module xbus_ram #(
  parameter logic [21:0] BASE      = 22'h001000,
  parameter int          ADDR_BITS = 8,
  parameter int          WAIT      = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [21:0] addrin,
  input  logic [31:0] datain,
  input  logic        reqin,
  input  logic        writein,
  output logic        decodeout,
  output logic        ackout,
  output logic [31:0] dataout,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
  output logic [1:0]  ram_state
);

  localparam int         DEPTH    = 1 << ADDR_BITS;
  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  typedef enum logic [1:0] {
    s_idle = 2'd0,
    s_wait = 2'd1,
    s_ack  = 2'd2,
    s_hold = 2'd3
  } state_t;

  state_t                 state;
  logic [3:0]             wcnt;
  logic [ADDR_BITS-1:0]   addr_q;
  logic [31:0]            data_q;
  logic                   wr_q;
  logic [ADDR_BITS-1:0]   rd_idx;
  logic [31:0]            mem_rd;
  logic [31:0]            mem [0:DEPTH-1];

  // Window decode is purely combinational so the arbiter sees it immediately.
  assign decodeout = reqin && (addrin[21:ADDR_BITS] == BASE[21:ADDR_BITS]);
  assign ram_state = state;

  // Read index: with zero wait states the ack is entered on the capture edge,
  // so the live address must be used there; otherwise the latched one.
  always_comb begin
    rd_idx = addr_q;
    if (state == s_idle) begin
      rd_idx = addrin[ADDR_BITS-1:0];
    end
    mem_rd = mem[rd_idx];
  end

  // Storage array: no reset, written only at the edge closing the ack cycle.
  always_ff @(posedge clk) begin
    if (!reset && state == s_ack && wr_q) begin
      mem[addr_q] <= data_q;
    end
  end

  // Transfer FSM with registered ack, read data and transfer counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= s_idle;
      wcnt     <= 4'd0;
      addr_q   <= '0;
      data_q   <= 32'd0;
      wr_q     <= 1'b0;
      ackout   <= 1'b0;
      dataout  <= 32'd0;
      rd_count <= 16'd0;
      wr_count <= 16'd0;
    end else begin
      ackout  <= 1'b0;
      dataout <= 32'd0;
      case (state)
        s_idle: begin
          if (decodeout) begin
            addr_q <= addrin[ADDR_BITS-1:0];
            data_q <= datain;
            wr_q   <= writein;
            wcnt   <= WAIT_CNT;
            if (WAIT > 0) begin
              state <= s_wait;
            end else begin
              state  <= s_ack;
              ackout <= 1'b1;
              if (!writein) begin
                dataout <= mem_rd;
              end
            end
          end
        end
        s_wait: begin
          if (!reqin) begin
            state <= s_idle;
          end else begin
            wcnt <= wcnt - 4'd1;
            if (wcnt == 4'd1) begin
              state  <= s_ack;
              ackout <= 1'b1;
              if (!wr_q) begin
                dataout <= mem_rd;
              end
            end
          end
        end
        s_ack: begin
          state <= s_hold;
          if (wr_q) begin
            wr_count <= wr_count + 16'd1;
          end else begin
            rd_count <= rd_count + 16'd1;
          end
        end
        s_hold: begin
          // A master still holding reqin must not be acked a second time.
          if (!reqin) begin
            state <= s_idle;
          end
        end
        default: state <= s_idle;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_xbus_ram.sv
`default_nettype none
// ============================================================================
//  Module   : tb_xbus_ram
//  Purpose  : Directed self-checking bench for xbus_ram. Three instances with
//             WAIT = 2, 4 and 0 share the request bus; each step targets one
//             instance and checks only that instance's outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_xbus_ram;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [21:0] addrin = 22'd0;
  logic [31:0] datain = 32'd0;
  logic        reqin = 1'b0;
  logic        writein = 1'b0;

  logic        dec  [3];
  logic        ack  [3];
  logic [31:0] dout [3];
  logic [15:0] rc   [3];
  logic [15:0] wc   [3];
  logic [1:0]  st   [3];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int ack_cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // index 0: WAIT=2, index 1: WAIT=4, index 2: WAIT=0
  xbus_ram #(.BASE(22'h001000), .ADDR_BITS(8), .WAIT(2)) u_w2 (
    .clk(clk), .reset(reset), .addrin(addrin), .datain(datain), .reqin(reqin),
    .writein(writein), .decodeout(dec[0]), .ackout(ack[0]), .dataout(dout[0]),
    .rd_count(rc[0]), .wr_count(wc[0]), .ram_state(st[0]));

  xbus_ram #(.BASE(22'h001000), .ADDR_BITS(8), .WAIT(4)) u_w4 (
    .clk(clk), .reset(reset), .addrin(addrin), .datain(datain), .reqin(reqin),
    .writein(writein), .decodeout(dec[1]), .ackout(ack[1]), .dataout(dout[1]),
    .rd_count(rc[1]), .wr_count(wc[1]), .ram_state(st[1]));

  xbus_ram #(.BASE(22'h001000), .ADDR_BITS(8), .WAIT(0)) u_w0 (
    .clk(clk), .reset(reset), .addrin(addrin), .datain(datain), .reqin(reqin),
    .writein(writein), .decodeout(dec[2]), .ackout(ack[2]), .dataout(dout[2]),
    .rd_count(rc[2]), .wr_count(wc[2]), .ram_state(st[2]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One master transaction aimed at instance sel. reqin is raised just after
  // an edge; lat counts edges until ack is seen. The master keeps reqin high
  // through the edge that samples ack (plus 'extra' cycles), then leaves a
  // single idle gap. Inputs are scrambled after capture to prove latching.
  task automatic xfer(input int sel, input logic [21:0] a, input logic w,
                      input logic [31:0] d, input int extra,
                      output logic [31:0] rdata, output int lat, output int dbl);
    addrin = a; datain = d; writein = w; reqin = 1'b1;
    lat = 0; dbl = 0;
    do begin
      tick();
      lat++;
      if (lat == 1) begin
        addrin = a ^ 22'h000001; datain = ~d; writein = ~w;
      end
    end while (!ack[sel] && lat < 40);
    if (!ack[sel]) check("ack_timeout", {31'd0, ack[sel]}, 32'd1);
    rdata = dout[sel];
    ack_cyc = cyc;
    repeat (1 + extra) begin
      tick();
      if (ack[sel]) dbl++;
    end
    reqin = 1'b0;
    tick();
    if (ack[sel]) dbl++;
  endtask

  initial begin
    logic [31:0] rd;
    int lat, dbl, dbl_sum, bad, lat_bad;
    int c0, c1, c2;
    logic [7:0] b;

    // ---------------- reset state ----------------
    repeat (3) tick();
    reset = 1'b0;
    check("rst_state", {30'd0, st[0]}, 32'd0);
    check("rst_ack",   {31'd0, ack[0]}, 32'd0);
    check("rst_dout",  dout[0], 32'd0);
    check("rst_rdcnt", {16'd0, rc[0]}, 32'd0);
    check("rst_wrcnt", {16'd0, wc[0]}, 32'd0);

    // ---------------- write then read, WAIT=2 ----------------
    xfer(0, 22'h001005, 1'b1, 32'hdeadbeef, 0, rd, lat, dbl);
    check("wr_latency", lat, 32'd3);
    xfer(0, 22'h001005, 1'b0, 32'h0, 0, rd, lat, dbl);
    check("rd_latency", lat, 32'd3);
    check("rd_data",    rd, 32'hdeadbeef);
    check("wr_count_1", {16'd0, wc[0]}, 32'd1);
    check("rd_count_1", {16'd0, rc[0]}, 32'd1);
    check("dout_idle",  dout[0], 32'd0);

    // ---------------- decode and out-of-window ----------------
    addrin = 22'h0010ff; reqin = 1'b1; #1;
    check("decode_hit", {31'd0, dec[0]}, 32'd1);
    reqin = 1'b0; #1;
    check("decode_noreq", {31'd0, dec[0]}, 32'd0);
    addrin = 22'h002000; writein = 1'b1; datain = 32'h12345678; reqin = 1'b1; #1;
    check("decode_miss", {31'd0, dec[0]}, 32'd0);
    bad = 0;
    repeat (20) begin
      tick();
      if (dec[0] || ack[0] || st[0] != 2'd0) bad++;
    end
    check("oow_quiet", bad, 32'd0);
    check("oow_wrcnt", {16'd0, wc[0]}, 32'd1);
    check("oow_rdcnt", {16'd0, rc[0]}, 32'd1);
    reqin = 1'b0;
    tick();

    // ---------------- abort, WAIT=4 ----------------
    xfer(1, 22'h001010, 1'b1, 32'h5, 0, rd, lat, dbl);
    check("w4_latency", lat, 32'd5);
    reset = 1'b1; tick(); reset = 1'b0;
    addrin = 22'h001010; datain = 32'h1; writein = 1'b1; reqin = 1'b1;
    bad = 0;
    tick(); if (ack[1]) bad++;
    check("abort_in_wait", {30'd0, st[1]}, 32'd1);
    tick(); if (ack[1]) bad++;
    reqin = 1'b0;
    tick(); if (ack[1]) bad++;
    tick(); if (ack[1]) bad++;
    check("abort_no_ack", bad, 32'd0);
    check("abort_state",  {30'd0, st[1]}, 32'd0);
    check("abort_wrcnt",  {16'd0, wc[1]}, 32'd0);
    xfer(1, 22'h001010, 1'b0, 32'h0, 0, rd, lat, dbl);
    check("abort_rd_data", rd, 32'h5);
    check("abort_rdcnt",   {16'd0, rc[1]}, 32'd1);

    // ---------------- DMA sweep, WAIT=2, extra hold cycle ----------------
    reset = 1'b1; tick(); reset = 1'b0;
    dbl_sum = 0; lat_bad = 0;
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      xfer(0, 22'h001000 + 22'(i), 1'b1, {b, b, b, b}, 1, rd, lat, dbl);
      dbl_sum += dbl;
      if (lat != 3) lat_bad++;
    end
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      xfer(0, 22'h001000 + 22'(i), 1'b0, 32'h0, 1, rd, lat, dbl);
      dbl_sum += dbl;
      if (lat != 3) lat_bad++;
      check($sformatf("sweep_rd_%0d", i), rd, {b, b, b, b});
    end
    check("sweep_double_ack", dbl_sum, 32'd0);
    check("sweep_latency",    lat_bad, 32'd0);
    check("sweep_wrcnt", {16'd0, wc[0]}, 32'd256);
    check("sweep_rdcnt", {16'd0, rc[0]}, 32'd256);

    // ---------------- reset mid-wait, WAIT=2 ----------------
    xfer(0, 22'h001020, 1'b1, 32'h7, 0, rd, lat, dbl);
    addrin = 22'h001020; datain = 32'hcafef00d; writein = 1'b1; reqin = 1'b1;
    tick();
    check("rmw_in_wait", {30'd0, st[0]}, 32'd1);
    tick();
    reset = 1'b1; reqin = 1'b0;
    tick();
    check("rmw_ack",   {31'd0, ack[0]}, 32'd0);
    check("rmw_state", {30'd0, st[0]}, 32'd0);
    check("rmw_wrcnt", {16'd0, wc[0]}, 32'd0);
    check("rmw_rdcnt", {16'd0, rc[0]}, 32'd0);
    reset = 1'b0;
    tick();
    xfer(0, 22'h001020, 1'b0, 32'h0, 0, rd, lat, dbl);
    check("rmw_rd_data", rd, 32'h7);

    // ---------------- zero wait back-to-back, WAIT=0 ----------------
    xfer(2, 22'h001030, 1'b1, 32'ha0a0a0a0, 0, rd, lat, dbl);
    c0 = ack_cyc;
    check("w0_lat_0", lat, 32'd1);
    xfer(2, 22'h001031, 1'b1, 32'hb1b1b1b1, 0, rd, lat, dbl);
    c1 = ack_cyc;
    check("w0_lat_1", lat, 32'd1);
    xfer(2, 22'h001032, 1'b1, 32'hc2c2c2c2, 0, rd, lat, dbl);
    c2 = ack_cyc;
    check("w0_period_a", c1 - c0, 32'd3);
    check("w0_period_b", c2 - c1, 32'd3);
    xfer(2, 22'h001031, 1'b0, 32'h0, 0, rd, lat, dbl);
    check("w0_rd_data", rd, 32'hb1b1b1b1);
    check("w0_rd_lat",  lat, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
